cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: PREG_W, default `PREG_IDX_WIDTH, physical register tag width.
REQ-002 Parameter: FIFO_DEPTH, default 2, completion buffer entries per source; legal values 2 to 4.
REQ-003 Port: clock  input  1  system clock; all state updates on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: alu_done_valid / mult_done_valid / lsq_done_valid  input  1 each  completion request from ALU / MULT / LSQ.
REQ-006 Port: alu_done_tag / mult_done_tag / lsq_done_tag  input  PREG_W each  pdest tag of the completing instruction.
REQ-007 Port: alu_done_ready / mult_done_ready / lsq_done_ready  output  1 each  source buffer can accept a request.
REQ-008 Port: squash  input  1  synchronous pipeline flush (branch mispredict).
REQ-009 Port: cdb_valid  output  1  broadcast valid; drives the reservation station cdb_valid.
REQ-010 Port: cdb_tag  output  PREG_W  broadcast tag; drives the reservation station cdb_tag.
REQ-011 Port: cdb_src  output  2  winning source: 0=ALU, 1=MULT, 2=LSQ; 3 is never driven.

Function
REQ-012 Each source SHALL own a FIFO of FIFO_DEPTH tags with a count register.
REQ-013 x_done_ready SHALL equal (count_x < FIFO_DEPTH), computed from registered count only.
REQ-014 x_done_ready SHALL have no combinational path from any input.
REQ-015 A request SHALL be pushed at a posedge when x_done_valid and x_done_ready are both 1 and squash is 0.
REQ-016 When x_done_valid is 1 and x_done_ready is 0, the request SHALL be ignored; the source holds it.
REQ-017 At most one tag SHALL be broadcast per cycle.
REQ-018 Arbitration SHALL be round-robin over non-empty FIFO heads, starting from pointer rr_ptr (2 bits, values 0-2).
REQ-019 On a grant, rr_ptr SHALL become (winner+1) mod 3; with no grant, rr_ptr SHALL hold.
REQ-020 On a grant at a posedge, the winner's head SHALL be popped and cdb_valid/cdb_tag/cdb_src registered with the winner's head tag and source.
REQ-021 With no non-empty FIFO at a posedge, cdb_valid SHALL be registered 0; cdb_tag and cdb_src SHALL hold their previous values.
REQ-022 Latency: a request pushed at edge k SHALL be broadcast no earlier than edge k+1; there is no bypass.
REQ-023 Push and pop of the same FIFO at the same edge SHALL both take effect, leaving count unchanged.
REQ-024 The FIFO SHALL preserve per-source order, with read/write pointers wrapping modulo FIFO_DEPTH.
REQ-025 Squash=1 at a posedge SHALL empty all FIFOs, register cdb_valid=0, drop that cycle's requests, and hold rr_ptr.
REQ-026 A tag SHALL be broadcast exactly once, and no accepted tag SHALL be lost unless squashed.

Reset
REQ-027 Reset low SHALL immediately, without waiting for a clock edge, force: all counts and FIFO pointers 0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_src=0.
REQ-028 While reset is low, all three x_done_ready outputs SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard all buffered tags.
REQ-030 After reset deasserts, no broadcast SHALL occur until a new request is pushed.

Verification
REQ-031 Reset check: after reset deasserts -> cdb_valid=0, cdb_tag=0, cdb_src=0, all readies 1.
REQ-032 Single request: ALU tag 5 presented one cycle, pushed at edge k -> at edge k+1 cdb_valid=1, cdb_tag=5, cdb_src=0; at k+2 cdb_valid=0.
REQ-033 Round-robin: with rr_ptr=0, ALU=1, MULT=2 and LSQ=3 pushed at the same edge -> tags 1, 2, 3 broadcast on three consecutive edges, with cdb_src 0, 1, 2.
REQ-034 Back-pressure: MULT valid for 6 cycles with tags 10-15 while ALU and LSQ are valid every cycle -> mult_done_ready drops to 0 at count FIFO_DEPTH; the tags of all accepted MULT requests are broadcast in order; no duplicates.
REQ-035 Squash: two tags buffered per source, squash pulsed one cycle -> at the next edge cdb_valid=0, all readies 1, no buffered tag is ever broadcast.
REQ-036 Async reset: reset pulsed low between clock edges while cdb_valid=1 -> cdb_valid=0 immediately; buffered tags are never broadcast.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Collects completion tags from three execution sources (ALU, MULT, LSQ) into
// small per-source FIFOs and broadcasts at most one tag per cycle on the
// common data bus. Arbitration is round-robin over the non-empty FIFO heads.
// The broadcast is registered, so a tag pushed at one edge is broadcast at
// the next edge at the earliest.
//
// Ports
//   clock                  system clock, all state updates on posedge
//   reset                  asynchronous, active-low reset
//   {alu,mult,lsq}_done_valid  completion request from each source
//   {alu,mult,lsq}_done_tag    pdest tag of the completing instruction
//   {alu,mult,lsq}_done_ready  source FIFO has room (from registered count)
//   squash                 synchronous flush: empties all FIFOs
//   cdb_valid              broadcast valid
//   cdb_tag                broadcast tag
//   cdb_src                winning source: 0=ALU, 1=MULT, 2=LSQ
// -----------------------------------------------------------------------------
`ifndef PREG_IDX_WIDTH
`define PREG_IDX_WIDTH 6
`endif

module cdb_arbiter #(
    parameter int PREG_W     = `PREG_IDX_WIDTH,
    parameter int FIFO_DEPTH = 2                 // legal range 2..4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              alu_done_valid,
    input  logic [PREG_W-1:0] alu_done_tag,
    output logic              alu_done_ready,

    input  logic              mult_done_valid,
    input  logic [PREG_W-1:0] mult_done_tag,
    output logic              mult_done_ready,

    input  logic              lsq_done_valid,
    input  logic [PREG_W-1:0] lsq_done_tag,
    output logic              lsq_done_ready,

    input  logic              squash,

    output logic              cdb_valid,
    output logic [PREG_W-1:0] cdb_tag,
    output logic [1:0]        cdb_src
);

    localparam int NUM_SRC = 3;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    // Source-indexed views of the per-source ports.
    logic [NUM_SRC-1:0] src_valid;
    logic [PREG_W-1:0]  src_tag [NUM_SRC];
    logic [NUM_SRC-1:0] src_ready;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;

    // FIFO state.
    logic [PREG_W-1:0]  mem    [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr [NUM_SRC];
    logic [PTR_W-1:0]   rd_ptr [NUM_SRC];
    logic [CNT_W-1:0]   count  [NUM_SRC];

    // Arbitration.
    logic [1:0]         rr_ptr;
    logic [1:0]         winner;
    logic [1:0]         cand;
    logic               grant;
    logic [PREG_W-1:0]  head_tag;

    // Pointer increment with wrap at FIFO_DEPTH (depth need not be a power of 2).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // (p + k) mod 3 for source indices.
    function automatic logic [1:0] rr_step(input logic [1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return 2'(s);
    endfunction

    assign src_valid  = {lsq_done_valid, mult_done_valid, alu_done_valid};
    assign src_tag[0] = alu_done_tag;
    assign src_tag[1] = mult_done_tag;
    assign src_tag[2] = lsq_done_tag;

    // Readiness depends only on registered counts, so there is no
    // combinational path from any input to a ready output.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src_ready[g] = (count[g] < DEPTH_C);
        assign push[g]      = src_valid[g] & src_ready[g] & ~squash;
        assign pop[g]       = grant & (winner == 2'(g)) & ~squash;
    end

    assign alu_done_ready  = src_ready[0];
    assign mult_done_ready = src_ready[1];
    assign lsq_done_ready  = src_ready[2];

    // Round-robin search starting at rr_ptr. Only the registered counts are
    // examined, so a tag pushed this cycle cannot be granted until next edge.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        grant  = 1'b0;
        winner = rr_ptr;
        cand   = rr_ptr;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = rr_step(rr_ptr, i);
            if (!grant && (count[cand] != '0)) begin
                grant  = 1'b1;
                winner = cand;
            end
        end
    end

    assign head_tag = mem[winner][rd_ptr[winner]];

    // Control state: counts, pointers, round-robin pointer, broadcast regs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                count[s]  <= '0;
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
            end
            rr_ptr    <= 2'd0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_src   <= 2'd0;
        end else if (squash) begin
            // Flush: drop everything buffered, keep rr_ptr and last tag/src.
            for (int s = 0; s < NUM_SRC; s++) begin
                count[s]  <= '0;
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
            end
            cdb_valid <= 1'b0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s]) wr_ptr[s] <= ptr_inc(wr_ptr[s]);
                if (pop[s])  rd_ptr[s] <= ptr_inc(rd_ptr[s]);
                // Simultaneous push and pop leave the count unchanged.
                case ({push[s], pop[s]})
                    2'b10:   count[s] <= count[s] + CNT_W'(1);
                    2'b01:   count[s] <= count[s] - CNT_W'(1);
                    default: ;
                endcase
            end
            if (grant) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= head_tag;
                cdb_src   <= winner;
                rr_ptr    <= rr_step(winner, 1);
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

    // Tag storage.
    // NOTE: the storage array is deliberately not reset; only entries between
    // rd_ptr and wr_ptr are ever read, and the pointers are reset.
    always_ff @(posedge clock) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) mem[s][wr_ptr[s]] <= src_tag[s];
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter. A queue-based reference model tracks
// per-source buffered tags and the round-robin pointer; every cycle the DUT
// readies and broadcast outputs are compared with the model. Directed
// scenarios (reset, single request, round-robin, back-pressure, squash,
// asynchronous reset) are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int PREG_W     = 6;
    localparam int FIFO_DEPTH = 2;

    logic              clock;
    logic              reset;
    logic              alu_done_valid,  mult_done_valid,  lsq_done_valid;
    logic [PREG_W-1:0] alu_done_tag,    mult_done_tag,    lsq_done_tag;
    logic              alu_done_ready,  mult_done_ready,  lsq_done_ready;
    logic              squash;
    logic              cdb_valid;
    logic [PREG_W-1:0] cdb_tag;
    logic [1:0]        cdb_src;

    cdb_arbiter #(
        .PREG_W     (PREG_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .alu_done_valid  (alu_done_valid),
        .alu_done_tag    (alu_done_tag),
        .alu_done_ready  (alu_done_ready),
        .mult_done_valid (mult_done_valid),
        .mult_done_tag   (mult_done_tag),
        .mult_done_ready (mult_done_ready),
        .lsq_done_valid  (lsq_done_valid),
        .lsq_done_tag    (lsq_done_tag),
        .lsq_done_ready  (lsq_done_ready),
        .squash          (squash),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_src         (cdb_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    logic [PREG_W-1:0] q [3][$];
    int                rr_m;
    logic              exp_valid;
    logic [PREG_W-1:0] exp_tag;
    logic [1:0]        exp_src;

    // Back-pressure bookkeeping.
    logic              rec_mult = 1'b0;
    logic [PREG_W-1:0] seen_mult [$];
    logic [PREG_W-1:0] exp_mult  [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) q[s].delete();
        rr_m      = 0;
        exp_valid = 1'b0;
        exp_tag   = '0;
        exp_src   = 2'd0;
    endtask

    // One clock edge of the arbiter's behaviour, from its rules.
    task automatic model_step(input logic [2:0] v, input logic [PREG_W-1:0] t0,
                              input logic [PREG_W-1:0] t1, input logic [PREG_W-1:0] t2,
                              input logic sq);
        logic [PREG_W-1:0] tg [3];
        bit                acc [3];
        int                w;
        tg[0] = t0; tg[1] = t1; tg[2] = t2;
        if (sq) begin
            for (int s = 0; s < 3; s++) q[s].delete();
            exp_valid = 1'b0;
        end else begin
            for (int s = 0; s < 3; s++) acc[s] = v[s] && (q[s].size() < FIFO_DEPTH);
            w = -1;
            for (int k = 0; k < 3; k++) begin
                int s;
                s = (rr_m + k) % 3;
                if (w < 0 && q[s].size() > 0) w = s;
            end
            if (w >= 0) begin
                exp_valid = 1'b1;
                exp_tag   = q[w].pop_front();
                exp_src   = 2'(w);
                rr_m      = (w + 1) % 3;
            end else begin
                exp_valid = 1'b0;
            end
            for (int s = 0; s < 3; s++) if (acc[s]) q[s].push_back(tg[s]);
        end
    endtask

    // Called at a negedge: drive inputs, check readies, clock once, check bus.
    task automatic cycle(input logic [2:0] v, input logic [PREG_W-1:0] ta,
                         input logic [PREG_W-1:0] tm, input logic [PREG_W-1:0] tl,
                         input logic sq);
        alu_done_valid  = v[0]; alu_done_tag  = ta;
        mult_done_valid = v[1]; mult_done_tag = tm;
        lsq_done_valid  = v[2]; lsq_done_tag  = tl;
        squash          = sq;
        #1;
        check("alu_ready",  alu_done_ready,  q[0].size() < FIFO_DEPTH);
        check("mult_ready", mult_done_ready, q[1].size() < FIFO_DEPTH);
        check("lsq_ready",  lsq_done_ready,  q[2].size() < FIFO_DEPTH);
        model_step(v, ta, tm, tl, sq);
        @(posedge clock);
        #1;
        check("cdb_valid", cdb_valid, exp_valid);
        check("cdb_tag",   cdb_tag,   exp_tag);
        check("cdb_src",   cdb_src,   exp_src);
        if (rec_mult && cdb_valid && cdb_src == 2'd1) seen_mult.push_back(cdb_tag);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(3'b000, '0, '0, '0, 1'b0);
    endtask

    // Called at a negedge: pulse reset low between clock edges.
    task automatic do_reset();
        alu_done_valid = 1'b0; mult_done_valid = 1'b0; lsq_done_valid = 1'b0;
        squash = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_valid",      cdb_valid,       1'b0);
        check("rst_tag",        cdb_tag,         '0);
        check("rst_src",        cdb_src,         2'd0);
        check("rst_alu_ready",  alu_done_ready,  1'b1);
        check("rst_mult_ready", mult_done_ready, 1'b1);
        check("rst_lsq_ready",  lsq_done_ready,  1'b1);
        #1 reset = 1'b1;
        model_reset();
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit dropped;
        int mi;

        reset = 1'b1;
        alu_done_valid = 1'b0; mult_done_valid = 1'b0; lsq_done_valid = 1'b0;
        alu_done_tag = '0; mult_done_tag = '0; lsq_done_tag = '0;
        squash = 1'b0;
        model_reset();
        @(negedge clock);

        // Reset state, then idle: nothing is broadcast.
        do_reset();
        idle(2);

        // Single ALU request: broadcast one edge after the push, then idle.
        cycle(3'b001, 6'd5, '0, '0, 1'b0);
        check("single_no_bypass", cdb_valid, 1'b0);
        cycle(3'b000, '0, '0, '0, 1'b0);
        check("single_valid", cdb_valid, 1'b1);
        check("single_tag",   cdb_tag,   6'd5);
        check("single_src",   cdb_src,   2'd0);
        cycle(3'b000, '0, '0, '0, 1'b0);
        check("single_done",  cdb_valid, 1'b0);

        // Round-robin from rr_ptr=0.
        do_reset();
        cycle(3'b111, 6'd1, 6'd2, 6'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(3'b000, '0, '0, '0, 1'b0);
            check("rr_tag", cdb_tag, 32'(i + 1));
            check("rr_src", cdb_src, 32'(i));
        end
        idle(1);
        check("rr_empty", cdb_valid, 1'b0);

        // Back-pressure: MULT holds each request until accepted.
        do_reset();
        rec_mult = 1'b1;
        seen_mult.delete();
        exp_mult.delete();
        dropped = 1'b0;
        mi = 0;
        for (int c = 0; c < 6; c++) begin
            bit acc;
            acc = mult_done_ready;
            if (!acc) dropped = 1'b1;
            cycle(3'b111, PREG_W'($urandom), PREG_W'(10 + mi), PREG_W'($urandom), 1'b0);
            if (acc) begin
                exp_mult.push_back(PREG_W'(10 + mi));
                mi++;
            end
        end
        idle(10);
        rec_mult = 1'b0;
        check("bp_ready_dropped", dropped, 1'b1);
        check("bp_mult_count", seen_mult.size(), exp_mult.size());
        for (int i = 0; i < exp_mult.size() && i < seen_mult.size(); i++)
            check("bp_mult_order", seen_mult[i], exp_mult[i]);

        // Squash with tags buffered in every source.
        do_reset();
        for (int c = 0; c < 3; c++)
            cycle(3'b111, PREG_W'(20 + c), PREG_W'(30 + c), PREG_W'(40 + c), 1'b0);
        cycle(3'b111, 6'd50, 6'd51, 6'd52, 1'b1);
        check("sq_valid",      cdb_valid,       1'b0);
        check("sq_alu_ready",  alu_done_ready,  1'b1);
        check("sq_mult_ready", mult_done_ready, 1'b1);
        check("sq_lsq_ready",  lsq_done_ready,  1'b1);
        idle(4);

        // Asynchronous reset while a broadcast is on the bus.
        cycle(3'b111, 6'd7, 6'd8, 6'd9, 1'b0);
        cycle(3'b000, '0, '0, '0, 1'b0);
        check("ar_pre_valid", cdb_valid, 1'b1);
        do_reset();
        idle(4);

        // Randomized traffic with occasional squash.
        for (int c = 0; c < 400; c++) begin
            cycle(3'($urandom), PREG_W'($urandom), PREG_W'($urandom), PREG_W'($urandom),
                  ($urandom_range(0, 24) == 0));
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
